// File: rtl/i2c_codec_pkg.sv
// Shared types and constants for the WM8731-style I2C control-port responder.
package i2c_codec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_BYTE1,
        ST_ACK_1,
        ST_BYTE2,
        ST_ACK_2,
        ST_IGNORE
    } i2c_state_t;

    localparam logic [6:0]  DEV_ADDR_DEFAULT = 7'h1A;
    localparam logic [6:0]  RESET_REG        = 7'h0F;
    localparam logic [3:0]  ACTIVE_REG       = 4'd9;
    localparam int unsigned REG_AW           = 4;

    // Power-on register contents, entry 0 in the least significant slot.
    localparam logic [15:0][8:0] REG_DEFAULTS = {
        9'h000, 9'h000, 9'h000, 9'h000,
        9'h000, 9'h000, 9'h000, 9'h000,
        9'h00A, 9'h09F, 9'h008, 9'h00A,
        9'h079, 9'h079, 9'h097, 9'h097
    };

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizes one raw I2C line, suppresses short glitches and flags edges
// of the filtered level.
module i2c_line_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(FILT_LEN + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-stage synchronizer; an idle bus reads high.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], line_in};
        end
    end

    // The first differing sample arms the counter; the level only flips once
    // FILT_LEN further samples agree, so pulses up to FILT_LEN cycles are lost.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            level <= 1'b1;
            cnt_q <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(FILT_LEN)) begin
                level <= sync_q[1];
                cnt_q <= '0;
                rise  <= sync_q[1];
                fall  <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_codec_slave.sv
// Write-only I2C responder standing in for the WM8731 control port: decodes
// address + two data bytes, ACKs them and commits into a 16x9 register file.
module i2c_codec_slave
    import i2c_codec_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [6:0] wr_reg,
    output logic [8:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       codec_active,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .line_in (scl_in),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .line_in (sda_in),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    i2c_state_t  state_q, state_d;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  shreg_q;
    logic [7:0]  byte1_q;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        commit;
    logic [8:0]  regs [NUM_REGS];

    logic start_ev, stop_ev, byte_full, addr_match;

    assign start_ev   = sda_fall & scl_lvl;
    assign stop_ev    = sda_rise & scl_lvl;
    assign byte_full  = (bit_cnt_q == 4'd8);
    assign addr_match = (shreg_q == {DEV_ADDR, 1'b0});

    // State register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: START/STOP override everything; byte/ACK phases advance on SCL falls.
    always_comb begin
        state_d = state_q;
        if (start_ev) begin
            state_d = ST_ADDR;
        end else if (stop_ev) begin
            state_d = ST_IDLE;
        end else if (scl_fall) begin
            case (state_q)
                ST_ADDR:  if (byte_full) state_d = addr_match ? ST_ACK_A : ST_IGNORE;
                ST_BYTE1: if (byte_full) state_d = ST_ACK_1;
                ST_BYTE2: if (byte_full) state_d = ST_ACK_2;
                ST_ACK_A: state_d = ST_BYTE1;
                ST_ACK_1: state_d = ST_BYTE2;
                ST_ACK_2: state_d = ST_IGNORE;
                default:  ;
            endcase
        end
    end

    // Outputs: next SDA drive and busy, plus the commit strobe at the last ACK's rising edge.
    always_comb begin
        sda_oe_d = sda_oe_q;
        busy_d   = busy_q;
        commit   = 1'b0;
        if (start_ev) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
        end else if (stop_ev) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            if (scl_fall) begin
                case (state_q)
                    ST_ADDR:                      if (byte_full) sda_oe_d = addr_match;
                    ST_BYTE1, ST_BYTE2:           if (byte_full) sda_oe_d = 1'b1;
                    ST_ACK_A, ST_ACK_1, ST_ACK_2: sda_oe_d = 1'b0;
                    default:                      ;
                endcase
            end
            if (scl_rise && state_q == ST_ACK_2) begin
                commit = 1'b1;
            end
        end
    end

    // Bit shifter, byte capture and registered outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            byte1_q   <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_valid  <= 1'b0;
            wr_reg    <= '0;
            wr_data   <= '0;
        end else begin
            sda_oe_q <= sda_oe_d;
            busy_q   <= busy_d;
            wr_valid <= commit;
            if (commit) begin
                wr_reg  <= byte1_q[7:1];
                wr_data <= {byte1_q[0], shreg_q};
            end
            if (start_ev || stop_ev) begin
                bit_cnt_q <= '0;
                shreg_q   <= '0;
            end else if (scl_rise && !byte_full &&
                         (state_q == ST_ADDR || state_q == ST_BYTE1 || state_q == ST_BYTE2)) begin
                shreg_q   <= {shreg_q[6:0], sda_lvl};
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall &&
                         (state_q == ST_ACK_A || state_q == ST_ACK_1 || state_q == ST_ACK_2)) begin
                bit_cnt_q <= '0;
            end
            if (scl_fall && byte_full && state_q == ST_BYTE1) begin
                byte1_q <= shreg_q;
            end
        end
    end

    // Register file: updated the cycle after wr_valid; the reset register reloads every default.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= REG_DEFAULTS[i[REG_AW-1:0]];
            end
        end else if (wr_valid) begin
            if (wr_reg == RESET_REG) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    regs[i] <= REG_DEFAULTS[i[REG_AW-1:0]];
                end
            end else if (32'(wr_reg) < NUM_REGS) begin
                regs[wr_reg[REG_AW-1:0]] <= wr_data;
            end
        end
    end

    assign sda_oe       = sda_oe_q;
    assign busy         = busy_q;
    assign rd_data      = regs[rd_addr];
    assign codec_active = regs[ACTIVE_REG][0];

endmodule

// File: tb/tb_i2c_codec_slave.sv
// Self-checking bench for i2c_codec_slave: table-driven transfers, hand-built
// corner sequences and randomized transfers against a transaction-level model.
module tb_i2c_codec_slave;

    localparam int Q = 8;                       // clk_sys cycles per quarter SCL period
    localparam logic [7:0] ADDR_W = 8'h34;      // device address 0x1A, write

    localparam logic [8:0] DEF [16] = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A,
        9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe, wr_valid, codec_active, busy;
    logic [6:0] wr_reg;
    logic [8:0] wr_data, rd_data;
    logic [3:0] rd_addr = '0;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] wr_q [$];
    logic        prev_oe = 1'b0;

    // Open-drain bus: either side can pull SDA low.
    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_codec_slave #(.DEV_ADDR(7'h1A), .NUM_REGS(16), .FILT_LEN(3)) dut (
        .clk_sys      (clk),
        .reset        (reset),
        .scl_in       (scl_m),
        .sda_in       (sda_bus),
        .sda_oe       (sda_oe),
        .wr_valid     (wr_valid),
        .wr_reg       (wr_reg),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .codec_active (codec_active),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Record every committed write; a stretched pulse shows up as extra entries.
    always @(negedge clk) begin
        if (wr_valid === 1'b1) wr_q.push_back({wr_reg, wr_data});
    end

    // SDA drive may only move while the master holds SCL low.
    always @(negedge clk) begin
        if (!reset && sda_oe !== prev_oe) check("sda_oe_moves_while_scl_low", 32'(scl_m), 32'd0);
        prev_oe = sda_oe;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic bit_out(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic ack_in(output logic acked);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        acked = ~sda_bus;
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        ack_in(acked);
    endtask

    task automatic check_all_defaults(input string name);
        for (int r = 0; r < 16; r++) begin
            rd_addr = 4'(r);
            tick(1);
            check(name, 32'(rd_data), 32'(DEF[r]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(5);
    endtask

    typedef struct {
        logic [3:0][7:0] bytes;   // bytes[0] is sent first
        int              nbytes;
        logic [3:0]      acks;    // bit k set: byte k must be ACKed
        int              nwr;
        logic [6:0]      wreg;
        logic [8:0]      wdata;
        logic [3:0]      rda;
        logic [8:0]      rdv;
        logic            active;
        logic            all_def;
    } vec_t;

    vec_t vec [9];

    logic        acked;
    logic [15:0] got;

    initial begin
        vec[0] = '{bytes:{8'h00, 8'h79, 8'h12, 8'h34}, nbytes:3, acks:4'b0111, nwr:1,
                   wreg:7'h09, wdata:9'h079, rda:4'd9, rdv:9'h079, active:1'b1, all_def:1'b0};
        vec[1] = '{bytes:{8'h00, 8'h00, 8'h00, 8'h36}, nbytes:1, acks:4'b0000, nwr:0,
                   wreg:7'h00, wdata:9'h000, rda:4'd9, rdv:9'h079, active:1'b1, all_def:1'b0};
        vec[2] = '{bytes:{8'h00, 8'h00, 8'h00, 8'h35}, nbytes:1, acks:4'b0000, nwr:0,
                   wreg:7'h00, wdata:9'h000, rda:4'd9, rdv:9'h079, active:1'b1, all_def:1'b0};
        vec[3] = '{bytes:{8'h00, 8'h14, 8'h08, 8'h34}, nbytes:3, acks:4'b0111, nwr:1,
                   wreg:7'h04, wdata:9'h014, rda:4'd4, rdv:9'h014, active:1'b1, all_def:1'b0};
        vec[4] = '{bytes:{8'h00, 8'h00, 8'h1E, 8'h34}, nbytes:3, acks:4'b0111, nwr:1,
                   wreg:7'h0F, wdata:9'h000, rda:4'd4, rdv:9'h00A, active:1'b0, all_def:1'b1};
        vec[5] = '{bytes:{8'h00, 8'h00, 8'h08, 8'h34}, nbytes:2, acks:4'b0011, nwr:0,
                   wreg:7'h00, wdata:9'h000, rda:4'd4, rdv:9'h00A, active:1'b0, all_def:1'b0};
        vec[6] = '{bytes:{8'h00, 8'hFF, 8'h21, 8'h34}, nbytes:3, acks:4'b0111, nwr:1,
                   wreg:7'h10, wdata:9'h1FF, rda:4'd0, rdv:9'h097, active:1'b0, all_def:1'b1};
        vec[7] = '{bytes:{8'hAA, 8'h79, 8'h12, 8'h34}, nbytes:4, acks:4'b0111, nwr:1,
                   wreg:7'h09, wdata:9'h079, rda:4'd9, rdv:9'h079, active:1'b1, all_def:1'b0};
        vec[8] = '{bytes:{8'h00, 8'h55, 8'h01, 8'h34}, nbytes:3, acks:4'b0111, nwr:1,
                   wreg:7'h00, wdata:9'h155, rda:4'd0, rdv:9'h155, active:1'b1, all_def:1'b0};

        // Reset state.
        do_reset();
        check("reset_sda_oe", 32'(sda_oe), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wr_valid", 32'(wr_valid), 32'd0);
        check("reset_wr_reg", 32'(wr_reg), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);
        check("reset_codec_active", 32'(codec_active), 32'd0);
        check_all_defaults("reset_reg_default");

        // Table-driven transfers.
        for (int v = 0; v < 9; v++) begin
            wr_q.delete();
            i2c_start();
            check("busy_after_start", 32'(busy), 32'd1);
            for (int k = 0; k < vec[v].nbytes; k++) begin
                send_byte(vec[v].bytes[k], acked);
                check($sformatf("vec%0d_ack%0d", v, k), 32'(acked), 32'(vec[v].acks[k]));
            end
            i2c_stop();
            check($sformatf("vec%0d_busy_after_stop", v), 32'(busy), 32'd0);
            check($sformatf("vec%0d_wr_count", v), 32'(wr_q.size()), 32'(vec[v].nwr));
            if (vec[v].nwr == 1 && wr_q.size() > 0) begin
                got = wr_q[0];
                check($sformatf("vec%0d_wr_reg", v), 32'(got[15:9]), 32'(vec[v].wreg));
                check($sformatf("vec%0d_wr_data", v), 32'(got[8:0]), 32'(vec[v].wdata));
            end
            rd_addr = vec[v].rda;
            tick(1);
            check($sformatf("vec%0d_rd_data", v), 32'(rd_data), 32'(vec[v].rdv));
            check($sformatf("vec%0d_codec_active", v), 32'(codec_active), 32'(vec[v].active));
            if (vec[v].all_def) check_all_defaults($sformatf("vec%0d_all_default", v));
        end

        // Repeated START in the middle of the address byte: only the full write lands.
        wr_q.delete();
        i2c_start();
        bit_out(1'b0); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
        i2c_start();
        send_byte(ADDR_W, acked); check("rstart_ack_addr", 32'(acked), 32'd1);
        send_byte(8'h03, acked);  check("rstart_ack_b1", 32'(acked), 32'd1);
        send_byte(8'h33, acked);  check("rstart_ack_b2", 32'(acked), 32'd1);
        i2c_stop();
        check("rstart_wr_count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) check("rstart_wr", 32'(wr_q[0]), 32'({7'h01, 9'h133}));
        rd_addr = 4'd1; tick(1);
        check("rstart_rd1", 32'(rd_data), 32'h133);

        // Three-cycle SCL glitch inside BYTE1 must not shift an extra bit.
        wr_q.delete();
        i2c_start();
        send_byte(ADDR_W, acked); check("glitch_ack_addr", 32'(acked), 32'd1);
        bit_out(1'b0); bit_out(1'b0); bit_out(1'b0);
        sda_m = 1'b0; tick(2);
        scl_m = 1'b1; tick(3);
        scl_m = 1'b0; tick(Q);
        bit_out(1'b0); bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
        ack_in(acked);            check("glitch_ack_b1", 32'(acked), 32'd1);
        send_byte(8'h42, acked);  check("glitch_ack_b2", 32'(acked), 32'd1);
        i2c_stop();
        check("glitch_wr_count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) check("glitch_wr", 32'(wr_q[0]), 32'({7'h05, 9'h042}));
        rd_addr = 4'd5; tick(1);
        check("glitch_rd5", 32'(rd_data), 32'h042);

        // Asynchronous reset while the slave is holding the address ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_out(ADDR_W[i]);
        tick(2);
        check("areset_oe_before", 32'(sda_oe), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("areset_oe_released", 32'(sda_oe), 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        scl_m = 1'b1; sda_m = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(5);
        check_all_defaults("areset_reg_default");

        // Randomized transfers against a transaction-level model.
        begin
            logic [8:0]      mdl [16];
            logic [15:0]     exp_q [$];
            logic [3:0][7:0] b;
            int              n;
            logic            addr_ok;
            logic [6:0]      r;
            logic [8:0]      d;

            for (int i = 0; i < 16; i++) mdl[i] = DEF[i];
            for (int t = 0; t < 25; t++) begin
                n = $urandom_range(1, 4);
                b[0] = ($urandom_range(0, 3) != 0) ? ADDR_W : 8'($urandom);
                b[1] = 8'($urandom_range(0, 47));
                b[2] = 8'($urandom);
                b[3] = 8'($urandom);
                addr_ok = (b[0] == ADDR_W);

                wr_q.delete();
                exp_q.delete();
                i2c_start();
                for (int k = 0; k < n; k++) begin
                    send_byte(b[k], acked);
                    check($sformatf("rnd%0d_ack%0d", t, k), 32'(acked), 32'(addr_ok && k < 3));
                end
                i2c_stop();

                if (addr_ok && n >= 3) begin
                    r = b[1][7:1];
                    d = {b[1][0], b[2]};
                    exp_q.push_back({r, d});
                    if (r == 7'h0F) begin
                        for (int i = 0; i < 16; i++) mdl[i] = DEF[i];
                    end else if (r < 7'd16) begin
                        mdl[r[3:0]] = d;
                    end
                end

                check($sformatf("rnd%0d_busy", t), 32'(busy), 32'd0);
                check($sformatf("rnd%0d_wr_count", t), 32'(wr_q.size()), 32'(exp_q.size()));
                if (exp_q.size() > 0 && wr_q.size() > 0)
                    check($sformatf("rnd%0d_wr", t), 32'(wr_q[0]), 32'(exp_q[0]));
                for (int i = 0; i < 16; i++) begin
                    rd_addr = 4'(i);
                    tick(1);
                    check($sformatf("rnd%0d_reg%0d", t, i), 32'(rd_data), 32'(mdl[i]));
                end
                check($sformatf("rnd%0d_codec_active", t), 32'(codec_active), 32'(mdl[9][0]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
